// File: rtl/td4_pkg.sv
// Shared types and constants for the TD4 execution controller: state encoding,
// CMD opcode values and instruction-word field helpers.
package td4_pkg;

  localparam int INSN_W     = 8;
  localparam int FIELD_W    = 4;
  localparam int ADDR_W     = 4;
  localparam int PROG_DEPTH = 1 << ADDR_W;

  typedef logic [INSN_W-1:0]  td4_insn_t;
  typedef logic [FIELD_W-1:0] td4_field_t;
  typedef logic [ADDR_W-1:0]  td4_addr_t;

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } td4_state_e;

  // TD4 CMD field values (upper nibble of each instruction word).
  localparam td4_field_t OP_ADD_A_IM = 4'b0000;
  localparam td4_field_t OP_MOV_A_B  = 4'b0001;
  localparam td4_field_t OP_IN_A     = 4'b0010;
  localparam td4_field_t OP_MOV_A_IM = 4'b0011;
  localparam td4_field_t OP_MOV_B_A  = 4'b0100;
  localparam td4_field_t OP_ADD_B_IM = 4'b0101;
  localparam td4_field_t OP_IN_B     = 4'b0110;
  localparam td4_field_t OP_MOV_B_IM = 4'b0111;
  localparam td4_field_t OP_OUT_B    = 4'b1001;
  localparam td4_field_t OP_OUT_IM   = 4'b1011;
  localparam td4_field_t OP_JNC_IM   = 4'b1110;
  localparam td4_field_t OP_JMP_IM   = 4'b1111;

  function automatic td4_field_t insn_cmd(input td4_insn_t w);
    return w[INSN_W-1:FIELD_W];
  endfunction

  function automatic td4_field_t insn_data(input td4_insn_t w);
    return w[FIELD_W-1:0];
  endfunction

endpackage

// File: rtl/td4_exec_ctrl_if.sv
// Program-load and core-fetch bus between the TD4 core/loader (master) and the
// execution controller (slave).
interface td4_exec_ctrl_if;
  import td4_pkg::*;

  logic       prog_we;
  td4_addr_t  prog_addr;
  td4_insn_t  prog_data;
  td4_addr_t  pc;
  td4_field_t cmd;
  td4_field_t data;
  logic       cpu_en;

  modport master (
    output prog_we, prog_addr, prog_data, pc,
    input  cmd, data, cpu_en
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, pc,
    output cmd, data, cpu_en
  );
endinterface

// File: rtl/td4_prog_store.sv
// 16x8 program register file: synchronous write, combinational read.
module td4_prog_store
  import td4_pkg::*;
(
  input  logic      clk,
  input  logic      we,
  input  td4_addr_t waddr,
  input  td4_insn_t wdata,
  input  td4_addr_t raddr,
  output td4_insn_t rdata
);

  td4_insn_t mem [PROG_DEPTH];

  // NOTE: storage has no reset on purpose so a loaded program survives clr;
  // only the write port is clocked.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/td4_exec_ctrl.sv
// TD4 execution sequencer: program store, HALT/RUN/STEP control, run-rate divider,
// step edge detector and retired counter. Optional breakpoint: TD4_BREAKPOINT_EN.
module td4_exec_ctrl
  import td4_pkg::*;
#(
  parameter int DIV   = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             run_req,
  input  logic             halt_req,
  input  logic             step_req,
  td4_exec_ctrl_if.slave   bus,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] retired
`ifdef TD4_BREAKPOINT_EN
  ,
  input  td4_addr_t        bp_addr,
  output logic             bp_hit
`endif
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  td4_state_e       state_q;
  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_nxt;
  logic             cpu_en_q;
  logic             step_q;
  logic             step_rise;
  logic             bp_block;
  td4_insn_t        insn;

  td4_prog_store u_prog_store (
    .clk   (clk),
    .we    (bus.prog_we && (state_q == ST_HALT)),
    .waddr (bus.prog_addr),
    .wdata (bus.prog_data),
    .raddr (bus.pc),
    .rdata (insn)
  );

  assign bus.cmd    = insn_cmd(insn);
  assign bus.data   = insn_data(insn);
  assign bus.cpu_en = cpu_en_q;
  assign state      = state_q;

  assign step_rise = step_req & ~step_q;
  assign div_nxt   = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;

`ifdef TD4_BREAKPOINT_EN
  assign bp_block = (bus.pc == bp_addr);
`else
  assign bp_block = 1'b0;
`endif

  // NOTE: every register here is updated with <= so all branches see the
  // pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q  <= ST_HALT;
      div_cnt  <= '0;
      cpu_en_q <= 1'b0;
      step_q   <= 1'b0;
      retired  <= '0;
`ifdef TD4_BREAKPOINT_EN
      bp_hit   <= 1'b0;
`endif
    end else begin
      step_q <= step_req;
      if (cpu_en_q && (retired != '1)) retired <= retired + 1'b1;

      unique case (state_q)
        ST_HALT: begin
          cpu_en_q <= 1'b0;
          div_cnt  <= '0;
          if (halt_req) begin
            state_q <= ST_HALT;
          end else if (step_rise) begin
            // Stepping deliberately executes over a breakpoint.
            state_q  <= ST_STEP;
            cpu_en_q <= 1'b1;
`ifdef TD4_BREAKPOINT_EN
            bp_hit   <= 1'b0;
`endif
          end else if (run_req) begin
            if ((DIV_LAST == '0) && bp_block) begin
              state_q <= ST_HALT;
`ifdef TD4_BREAKPOINT_EN
              bp_hit  <= 1'b1;
`endif
            end else begin
              state_q  <= ST_RUN;
              cpu_en_q <= (DIV_LAST == '0);
`ifdef TD4_BREAKPOINT_EN
              bp_hit   <= 1'b0;
`endif
            end
          end
        end

        ST_RUN: begin
          if (halt_req || !run_req) begin
            state_q  <= ST_HALT;
            cpu_en_q <= 1'b0;
            div_cnt  <= '0;
          end else if ((div_nxt == DIV_LAST) && bp_block) begin
            // The pulse that would execute the breakpoint PC is swallowed.
            state_q  <= ST_HALT;
            cpu_en_q <= 1'b0;
            div_cnt  <= '0;
`ifdef TD4_BREAKPOINT_EN
            bp_hit   <= 1'b1;
`endif
          end else begin
            div_cnt  <= div_nxt;
            cpu_en_q <= (div_nxt == DIV_LAST);
          end
        end

        ST_STEP: begin
          state_q  <= ST_HALT;
          cpu_en_q <= 1'b0;
          div_cnt  <= '0;
        end

        default: begin
          state_q  <= ST_HALT;
          cpu_en_q <= 1'b0;
          div_cnt  <= '0;
        end
      endcase
    end
  end

endmodule
